spiker_reader: RTL and testbench
================================

// Module: spiker_reader
// PURPOSE
//  Register-to-core direction of the spiker adapter, the counterpart of the result-sampling path.
//  Collects N_REG software-written spike words into a shadow buffer and tracks which words are written.
//  On a start command with all words present, copies the buffer into an output register.
//  Presents it to the spiker core as one DATA_WIDTH vector over a valid/ready handshake.
//  The shadow buffer can be refilled while a frame is pending.
// PARAMETERS
//  WIDTH      32   bits per spike word
//  N_SPIKES   784  number of meaningful input spikes; data_in_o bits >= N_SPIKES are forced to 0
//  N_REG      25   number of spike words; N_REG*WIDTH == DATA_WIDTH (elaboration assertion)
//  DATA_WIDTH 800  core input vector width
//  CNT_WIDTH  16   width of completed-frame counter
// PORTS
//  clk_i          in   1                  clock
//  rst_ni         in   1                  reset, asynchronous, active-low
//  wr_en_i        in   1                  spike word write strobe (from register file)
//  wr_idx_i       in   $clog2(N_REG)+1    target word index
//  wr_data_i      in   WIDTH              word value
//  start_i        in   1                  single-cycle start command
//  clear_i        in   1                  synchronous soft clear
//  data_in_o      out  DATA_WIDTH         spike vector to core; word i at [(i+1)*WIDTH-1 -: WIDTH]
//  valid_o        out  1                  data_in_o holds a frame
//  ready_i        in   1                  core accepts frame
//  done_o         out  1                  1-cycle pulse per completed handshake
//  busy_o         out  1                  1 while state == PRESENT
//  loaded_mask_o  out  N_REG              bit i = word i written since last arm/clear
//  err_o          out  3                  sticky: [0] idx >= N_REG, [1] start with mask incomplete, [2] start while PRESENT w/o reload
//  frame_cnt_o    out  CNT_WIDTH          completed handshakes, wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  Reset (async): all outputs 0, including data_in_o, mask, err_o, frame_cnt_o and done_o; state=COLLECT.
//    Shadow contents are don't-care.
//  Priority per edge: reset > clear_i > all else.
//  clear_i: state->COLLECT; valid_o, mask and err_o cleared.
//    frame_cnt_o, data_in_o and shadow are retained; a same-cycle write is dropped.
//  Write (any state): wr_en_i with idx < N_REG: shadow[idx] <= wr_data_i, mask[idx] <= 1. Rewriting a word is legal.
//    idx >= N_REG: no shadow/mask change, err_o[0] <= 1.
//  Arm: start_i accepted when mask == all-ones and (state == COLLECT, or state == PRESENT with valid_o & ready_i same cycle).
//    data_in_o <= pre-edge shadow with bits >= N_SPIKES zeroed; mask <= 0; state->PRESENT.
//    valid_o is 1 in the next cycle (1-cycle latency).
//    A write in the arm cycle lands in shadow after the copy; mask after the edge = only that bit.
//  start_i in COLLECT with incomplete mask: ignored, err_o[1] <= 1.
//  start_i in PRESENT without handshake that cycle: ignored, err_o[2] <= 1.
//  PRESENT: data_in_o and valid_o stable until valid_o & ready_i.
//    On handshake: done_o = 1 next cycle and frame_cnt_o += 1 (wraps).
//    If no accepted arm that cycle: valid_o <= 0, state->COLLECT.
//    If re-armed (back-to-back): valid_o stays 1 and data_in_o takes the new frame.
//  ready_i high while valid_o low: no effect.
//  States: COLLECT --start&full--> PRESENT --hs&!rearm--> COLLECT; PRESENT --hs&rearm--> PRESENT; any --clear--> COLLECT.
// TESTING
//  1 Write idx 0..24 with 32'h0101_0101*i, then start_i -> valid_o=1 next cycle, word i matches and [799:784]=0.
//    ready_i=1 -> done_o pulses once, frame_cnt_o=1, busy_o=0, mask=0.
//  2 Write all but idx 7, start_i -> err_o=3'b010, valid_o stays 0.
//    Write idx 7, start_i -> valid_o=1.
//  3 wr_idx_i=25, wr_data_i=32'hDEAD_BEEF -> err_o[0]=1, loaded_mask_o unchanged. clear_i -> err_o=0.
//  4 Hold ready_i=0 for 10 cycles in PRESENT, rewrite all 25 words -> data_in_o unchanged.
//    start_i -> err_o[2]=1.
//    ready_i=1 with start_i same cycle -> valid_o stays 1, new data, frame_cnt_o+1, mask=0.
//  5 Assert rst_ni=0 mid-PRESENT -> valid_o, mask, err_o, frame_cnt_o = 0 immediately.
//    Assert clear_i mid-PRESENT with a same-cycle write -> valid_o=0, mask=0, frame_cnt_o kept.
//  6 CNT_WIDTH=2: complete 5 frames -> frame_cnt_o sequence 1,2,3,0,1.

Source files
------------

// File: rtl/spiker_reader_if.sv
// Core-side frame handshake between the spiker reader and the spiker core.
//   data_in : full spike vector, word i at [(i+1)*WIDTH-1 -: WIDTH]
//   valid   : data_in holds a frame
//   ready   : core accepts the frame this cycle
// master = reader (drives data_in/valid), slave = core (drives ready).
interface spiker_reader_if #(
  parameter int unsigned DATA_WIDTH = 800
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid;
  logic                  ready;

  modport master (output data_in, output valid, input ready);
  modport slave  (input data_in, input valid, output ready);
endinterface

// File: rtl/spiker_reader.sv
// Register-to-core half of the spiker adapter.
// Software writes N_REG spike words into a shadow buffer; a start command with every word
// present copies the buffer (bits >= N_SPIKES zeroed) into the output register, which is then
// offered to the core over a valid/ready handshake. The shadow can be refilled while a frame
// is pending, and a start in the handshake cycle re-arms back-to-back.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   wr_en_i/wr_idx_i/wr_data_i   spike word write from the register file
//   start_i         single-cycle arm command
//   clear_i         synchronous soft clear (state, valid, mask, errors)
//   core_if         frame handshake to the core (data_in/valid out, ready in)
//   done_o          1-cycle pulse after each completed handshake
//   busy_o          frame pending
//   loaded_mask_o   bit i = word i written since last arm/clear
//   err_o           sticky: [0] bad index, [1] start with incomplete mask,
//                   [2] start while pending without a handshake
//   frame_cnt_o     completed handshakes, wrapping
module spiker_reader #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned N_SPIKES   = 784,
  parameter int unsigned N_REG      = 25,
  parameter int unsigned DATA_WIDTH = 800,
  parameter int unsigned CNT_WIDTH  = 16,
  localparam int unsigned IdxW      = $clog2(N_REG) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [IdxW-1:0]       wr_idx_i,
  input  logic [WIDTH-1:0]      wr_data_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  spiker_reader_if.master       core_if,
  output logic                  done_o,
  output logic                  busy_o,
  output logic [N_REG-1:0]      loaded_mask_o,
  output logic [2:0]            err_o,
  output logic [CNT_WIDTH-1:0]  frame_cnt_o
);

  if (N_REG * WIDTH != DATA_WIDTH) begin : g_bad_width
    $error("spiker_reader: N_REG*WIDTH must equal DATA_WIDTH");
  end
  if (N_SPIKES > DATA_WIDTH) begin : g_bad_spikes
    $error("spiker_reader: N_SPIKES must not exceed DATA_WIDTH");
  end

  // Padding bits above the meaningful spikes are always presented as 0.
  localparam logic [DATA_WIDTH-1:0] SpikeMask =
      (N_SPIKES >= DATA_WIDTH) ? {DATA_WIDTH{1'b1}}
                               : ((DATA_WIDTH'(1) << N_SPIKES) - DATA_WIDTH'(1));

  typedef enum logic [0:0] {StCollect, StPresent} state_e;

  state_e                 state_q, state_d;
  logic [N_REG-1:0]       mask_q, mask_d;
  logic [2:0]             err_q, err_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   done_q, done_d;

  logic [WIDTH-1:0]       shadow_q [N_REG];
  logic [DATA_WIDTH-1:0]  shadow_flat;

  logic valid;
  logic hs;
  logic idx_ok;
  logic arm;

  assign valid  = (state_q == StPresent);
  assign hs     = valid & core_if.ready;
  assign idx_ok = (wr_idx_i < IdxW'(N_REG));
  // A pending frame may only be replaced in the cycle it is consumed.
  assign arm    = start_i & (&mask_q) & ((state_q == StCollect) | hs);

  always_comb begin
    shadow_flat = '0;
    for (int i = 0; i < N_REG; i++) begin
      shadow_flat[i*WIDTH +: WIDTH] = shadow_q[i];
    end
  end

  // Shadow has no reset; its contents are meaningless until the mask says otherwise.
  // Writes land after the arm copy because the copy reads the pre-edge value.
  always_ff @(posedge clk_i) begin
    if (wr_en_i && !clear_i) begin
      for (int i = 0; i < N_REG; i++) begin
        if (wr_idx_i == IdxW'(i)) shadow_q[i] <= wr_data_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    err_d   = err_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (clear_i) begin
      state_d = StCollect;
      mask_d  = '0;
      err_d   = '0;
    end else begin
      if (arm) begin
        data_d  = shadow_flat & SpikeMask;
        mask_d  = '0;
        state_d = StPresent;
      end else if (start_i) begin
        if (state_q == StPresent && !hs) err_d[2] = 1'b1;
        else                             err_d[1] = 1'b1;
      end
      if (hs) begin
        done_d = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (!arm) state_d = StCollect;
      end
      // Applied after the arm clear so a write in the arm cycle survives in the mask.
      if (wr_en_i) begin
        if (idx_ok) begin
          for (int i = 0; i < N_REG; i++) begin
            if (wr_idx_i == IdxW'(i)) mask_d[i] = 1'b1;
          end
        end else begin
          err_d[0] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StCollect;
      mask_q  <= '0;
      err_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign core_if.data_in = data_q;
  assign core_if.valid   = valid;
  assign done_o          = done_q;
  assign busy_o          = valid;
  assign loaded_mask_o   = mask_q;
  assign err_o           = err_q;
  assign frame_cnt_o     = cnt_q;

endmodule

// File: tb/tb_spiker_reader.sv
module tb_spiker_reader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [5:0]  wr_idx;
  logic [31:0] wr_data;
  logic        start;
  logic        clear;
  logic        ready;

  logic        done, busy;
  logic [24:0] mask;
  logic [2:0]  err;
  logic [15:0] cnt;

  logic        done2, busy2;
  logic [24:0] mask2;
  logic [2:0]  err2;
  logic [1:0]  cnt2;

  int n_cmp = 0;
  int n_err = 0;

  spiker_reader_if #(.DATA_WIDTH(800)) bus1 ();
  spiker_reader_if #(.DATA_WIDTH(800)) bus2 ();
  assign bus1.ready = ready;
  assign bus2.ready = ready;

  spiker_reader u_dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data),
    .start_i(start), .clear_i(clear), .core_if(bus1), .done_o(done), .busy_o(busy),
    .loaded_mask_o(mask), .err_o(err), .frame_cnt_o(cnt)
  );

  spiker_reader #(.CNT_WIDTH(2)) u_dut_c2 (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_data_i(wr_data),
    .start_i(start), .clear_i(clear), .core_if(bus2), .done_o(done2), .busy_o(busy2),
    .loaded_mask_o(mask2), .err_o(err2), .frame_cnt_o(cnt2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int sel, input int i);
    case (sel)
      0:       pat = 32'h0101_0101 * i;
      1:       pat = 32'hFFFF_0000 ^ i;
      default: pat = 32'h1234_5678 + i * 32'h0011_0000;
    endcase
  endfunction

  function automatic logic [799:0] frame(input int sel);
    logic [799:0] f;
    for (int i = 0; i < 25; i++) f[i*32 +: 32] = pat(sel, i);
    f[799:784] = '0;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [799:0] obs, input logic [799:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks after tick see post-edge state.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int idx, input logic [31:0] d);
    wr_en = 1'b1; wr_idx = 6'(idx); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic fill(input int sel, input int skip);
    for (int i = 0; i < 25; i++) if (i != skip) wr(i, pat(sel, i));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    start = 1'b0; clear = 1'b0; ready = 1'b0;
    do_reset();

    // Reset state
    chk("rst_valid", bus1.valid, 0);
    chk("rst_data", bus1.data_in, 0);
    chk("rst_mask", mask, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);

    // 1: basic frame
    fill(0, -1);
    chk("t1_mask_full", mask, 25'h1FF_FFFF);
    do_start();
    chk("t1_valid", bus1.valid, 1);
    chk("t1_busy", busy, 1);
    chk("t1_data", bus1.data_in, frame(0));
    chk("t1_pad", bus1.data_in[799:784], 0);
    chk("t1_mask_clr", mask, 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_cnt", cnt, 1);
    chk("t1_busy_off", busy, 0);
    chk("t1_valid_off", bus1.valid, 0);
    tick();
    chk("t1_done_pulse", done, 0);

    // 2: start with incomplete mask
    fill(1, 7);
    do_start();
    chk("t2_err", err, 3'b010);
    chk("t2_valid_low", bus1.valid, 0);
    wr(7, pat(1, 7));
    do_start();
    chk("t2_valid", bus1.valid, 1);
    chk("t2_data", bus1.data_in, frame(1));
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("t2_cnt", cnt, 2);

    // 3: bad index, then clear
    wr(3, 32'h5555_AAAA);
    wr(25, 32'hDEAD_BEEF);
    chk("t3_err", err, 3'b011);
    chk("t3_mask", mask, 25'h8);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t3_err_clr", err, 0);
    chk("t3_mask_clr", mask, 0);
    chk("t3_cnt_kept", cnt, 2);

    // 4: stall, refill, back-to-back re-arm
    fill(1, -1);
    do_start();
    chk("t4_data1", bus1.data_in, frame(1));
    fill(2, -1);
    chk("t4_stable", bus1.data_in, frame(1));
    chk("t4_valid_held", bus1.valid, 1);
    do_start();
    chk("t4_err2", err, 3'b100);
    chk("t4_still_valid", bus1.valid, 1);
    start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0; ready = 1'b0;
    chk("t4_rearm_valid", bus1.valid, 1);
    chk("t4_rearm_data", bus1.data_in, frame(2));
    chk("t4_rearm_cnt", cnt, 3);
    chk("t4_rearm_done", done, 1);
    chk("t4_rearm_mask", mask, 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("t4_cnt_end", cnt, 4);
    chk("t4_valid_end", bus1.valid, 0);

    // 5: async reset mid-frame, then clear mid-frame
    fill(0, -1);
    do_start();
    wr(0, 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", bus1.valid, 0);
    chk("t5_rst_mask", mask, 0);
    chk("t5_rst_err", err, 0);
    chk("t5_rst_cnt", cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    fill(1, -1);
    do_start();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("t5_cnt1", cnt, 1);
    fill(2, -1);
    do_start();
    clear = 1'b1; wr_en = 1'b1; wr_idx = 6'd5; wr_data = 32'hCAFE_F00D;
    tick();
    clear = 1'b0; wr_en = 1'b0;
    chk("t5_clr_valid", bus1.valid, 0);
    chk("t5_clr_mask", mask, 0);
    chk("t5_clr_cnt", cnt, 1);
    chk("t5_clr_data", bus1.data_in, frame(2));

    // 6: 2-bit counter wrap
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      fill(0, -1);
      do_start();
      ready = 1'b1;
      tick();
      ready = 1'b0;
      chk($sformatf("t6_cnt%0d", k), cnt2, 800'(k % 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
